// File: rtl/serial_add_ctrl.sv
// Bit-serial adder with valid/ready handshake: one full-adder cell is reused
// LSB-first for WIDTH cycles to produce {cout, sum} = a + b + cin.

module add1 (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_s,
   output logic o_cout
);
   assign o_s    = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;

   logic w_sum_bit;
   logic w_carry_out;

   add1 u_add1 (
      .i_a    (r_a[0]),
      .i_b    (r_b[0]),
      .i_cin  (r_carry),
      .o_s    (w_sum_bit),
      .o_cout (w_carry_out)
   );

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values; blocking here would let r_carry see this cycle's update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else if (flush) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= cin;
                  r_cnt   <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               // Sum bits enter at the MSB so after WIDTH shifts bit 0 is at the LSB.
               r_sum   <= (r_sum >> 1) | (WIDTH'(w_sum_bit) << (WIDTH - 1));
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_carry <= w_carry_out;
               r_cnt   <= r_cnt + CW'(1);
               if (r_cnt == LAST_BIT) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // r_sum only moves during RUN, so IDLE naturally shows the last completed result.
   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign sum       = r_sum;
   assign cout      = r_carry;

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, SHALL be the operand width in bits, legal range 1..32.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 in_valid  input  1  SHALL indicate that a, b and cin carry a valid operation request.
REQ-005 in_ready  output  1  SHALL indicate the block accepts a request this cycle.
REQ-006 a  input  WIDTH  SHALL be operand A, unsigned.
REQ-007 b  input  WIDTH  SHALL be operand B, unsigned.
REQ-008 cin  input  1  SHALL be the carry-in.
REQ-009 flush  input  1  SHALL be the synchronous abort of any operation in progress.
REQ-010 out_valid  output  1  SHALL indicate sum and cout hold a completed result.
REQ-011 out_ready  input  1  SHALL indicate the consumer takes the result this cycle.
REQ-012 sum  output  WIDTH  SHALL be the result sum bits.
REQ-013 cout  output  1  SHALL be the result carry-out.
REQ-014 busy  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-015 The block SHALL compute {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), bit-serially, using exactly one instance of the 1-bit full-adder cell add1 for all bit positions.
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 in_ready SHALL equal (state == IDLE) and SHALL NOT depend combinationally on in_valid.
REQ-018 Acceptance SHALL occur on a rising edge where in_valid && in_ready && !flush. On acceptance: latch a and b into shift registers; load the carry register with cin; clear the bit counter; go to RUN.
REQ-019 In each RUN cycle, add1 SHALL receive operand-A shift LSB, operand-B shift LSB and the carry register. On the edge, the sum bit SHALL shift into the MSB of the sum shift register (right shift), both operand registers SHALL shift right, the carry register SHALL take add1 cout, and the counter SHALL increment.
REQ-020 RUN SHALL last exactly WIDTH cycles; the edge that processes bit WIDTH-1 SHALL move the FSM to DONE.
REQ-021 out_valid SHALL rise exactly WIDTH clock edges after the acceptance edge.
REQ-022 In DONE: out_valid = 1; sum = sum shift register; cout = carry register. sum and cout SHALL stay stable until the handshake completes.
REQ-023 A rising edge in DONE with out_ready = 1 SHALL return the FSM to IDLE. out_ready may already be high in the first DONE cycle.
REQ-024 In IDLE, sum and cout SHALL keep their last completed values, and out_valid SHALL be 0.
REQ-025 a, b, cin and in_valid changes after acceptance SHALL have no effect until the next IDLE.
REQ-026 flush = 1 on an edge SHALL force IDLE from any state and SHALL take priority over acceptance and over the out_ready handshake. sum and cout SHALL be cleared to 0; out_valid SHALL be 0 from the next cycle.
REQ-027 The minimum request-to-request spacing SHALL be WIDTH+2 cycles: accept, WIDTH RUN cycles, DONE handshake, then re-accept in IDLE.
REQ-028 The counter SHALL be wide enough to hold WIDTH, and SHALL NOT wrap within an operation.
REQ-029 For WIDTH = 1, RUN SHALL last one cycle and the result SHALL equal the add1 output for a[0], b[0], cin.

Reset
REQ-030 rst_n low SHALL immediately set state IDLE, and SHALL set to 0: in_ready... except in_ready, which SHALL be 1; out_valid 0, busy 0, sum 0, cout 0, all shift, carry and counter registers 0.
REQ-031 Reset asserted mid-RUN or in DONE SHALL discard the operation with no partial result visible.
REQ-032 After rst_n deasserts, the first acceptance SHALL be possible on the first rising edge.

Verification
REQ-033 WIDTH=8: a=0x5A, b=0x3C, cin=0 accepted -> out_valid rises 8 edges later with sum=0x96, cout=0.
REQ-034 WIDTH=8: a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1; out_ready held low 5 cycles -> result stable and in_ready=0 throughout.
REQ-035 Operands changed to random values each cycle during RUN -> result matches the values latched at acceptance.
REQ-036 flush asserted in RUN cycle 3, with in_valid high in the same cycle -> IDLE next edge, no acceptance, sum=0, out_valid never rises.
REQ-037 rst_n pulsed low in DONE -> out_valid=0 and sum=0 immediately; the next request completes correctly.
REQ-038 Random back-to-back requests (1000 ops, WIDTH=8 and WIDTH=1) with out_ready always high -> every result matches the reference model, spacing = WIDTH+2 cycles.
